// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH product split into halves.
// Signed operands are multiplied as magnitudes and the product is negated on completion.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_ONE     = WIDTH'(1);
    localparam logic [PW-1:0]    P_ONE     = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_lo_q;
    logic [WIDTH-1:0] out_hi_q;

    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    product_d;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        if (sm && v[WIDTH-1]) begin
            magnitude = ~v + W_ONE;
        end else begin
            magnitude = v;
        end
    endfunction

    // Accumulator after the current step and the signed-corrected final product.
    always_comb begin
        acc_d     = acc_q;
        product_d = '0;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
        if (sign_q) begin
            product_d = ~acc_d + P_ONE;
        end else begin
            product_d = acc_d;
        end
    end

    // Control FSM with datapath registers and registered status/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_lo_q <= '0;
            out_hi_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, magnitude(in_a, signed_mode)};
                        mplier_q <= magnitude(in_b, signed_mode);
                        sign_q   <= signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_STEP) begin
                        out_lo_q <= product_d[WIDTH-1:0];
                        out_hi_q <= product_d[PW-1:WIDTH];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        state_q  <= S_RUN;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out_lo = out_lo_q;
    assign out_hi = out_hi_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard-based bench for seq_multiplier: expected products are queued at start
// and compared when done pulses.
module tb_seq_multiplier;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        busy;
    logic        done;
    logic [15:0] out_lo;
    logic [15:0] out_hi;

    int          checks;
    int          failures;
    logic [31:0] sb_q[$];
    logic [31:0] last_prod;

    seq_multiplier #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .signed_mode(signed_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .busy       (busy),
        .done       (done),
        .out_lo     (out_lo),
        .out_hi     (out_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic sm);
        longint p;
        if (sm) p = longint'($signed(a)) * longint'($signed(b));
        else    p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // Single operation: one-cycle start, latency and pulse-width checks, scoreboard compare.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          input logic [31:0] exp, input string name);
        int busy_cnt;
        int cycles;
        logic [31:0] e;
        @(negedge clk);
        in_a = a; in_b = b; signed_mode = sm; start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); signed_mode = ~sm;
        busy_cnt = 0;
        cycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (busy_cnt !== 16 || cycles !== 16) begin
            failures++;
            $display("FAIL %s_latency busy_cycles=%0d done_after=%0d required 16/16", name, busy_cnt, cycles);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_state busy=%b done=%b required busy=0 done=1", name, busy, done);
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard_empty got=%h required an entry", name, {out_hi, out_lo});
        end else begin
            e = sb_q.pop_front();
            if ({out_hi, out_lo} !== e) begin
                failures++;
                $display("FAIL %s_product got=%h required=%h", name, {out_hi, out_lo}, e);
            end
            last_prod = e;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {out_hi, out_lo} !== last_prod) begin
            failures++;
            $display("FAIL %s_after_done busy=%b done=%b out=%h required 0/0/%h",
                     name, busy, done, {out_hi, out_lo}, last_prod);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; in_a = 16'h0; in_b = 16'h0;
        last_prod = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {out_hi, out_lo} !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b out=%h required 0/0/00000000", busy, done, {out_hi, out_lo});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(16'h0003, 16'h0005, 1'b0, 32'h0000_000F, "u_3x5");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "u_max");
    endtask

    task automatic test_signed();
        run_op(16'hFFFD, 16'h0004, 1'b1, 32'hFFFF_FFF4, "s_m3x4");
        run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "s_min_min");
        run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, "s_min_one");
        run_op(16'h1234, 16'hABCD, 1'b1, model(16'h1234, 16'hABCD, 1'b1), "s_mixed");
    endtask

    task automatic test_zero();
        run_op(16'h0000, 16'h1234, 1'b1, 32'h0, "zero_signed");
        run_op(16'h0000, 16'h1234, 1'b0, 32'h0, "zero_unsigned");
    endtask

    // start held high with operands changing every cycle; only IDLE samples count.
    task automatic test_back_to_back();
        int last_done;
        int n_done;
        logic [31:0] e;
        last_done = -1;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 100 && n_done < 3; cyc++) begin
            if (done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_scoreboard_empty got=%h", {out_hi, out_lo});
                end else begin
                    e = sb_q.pop_front();
                    if ({out_hi, out_lo} !== e) begin
                        failures++;
                        $display("FAIL b2b_product got=%h required=%h", {out_hi, out_lo}, e);
                    end
                    last_prod = e;
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done !== 18) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d required=18", cyc - last_done);
                    end
                end
                last_done = cyc;
                n_done++;
            end else begin
                checks++;
                if ({out_hi, out_lo} !== last_prod || (busy && done)) begin
                    failures++;
                    $display("FAIL b2b_hold got=%h required=%h busy=%b done=%b",
                             {out_hi, out_lo}, last_prod, busy, done);
                end
            end
            in_a = 16'($urandom); in_b = 16'($urandom); signed_mode = 1'($urandom);
            if (!busy && !done) sb_q.push_back(model(in_a, in_b, signed_mode));
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done !== 3 || sb_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_count done_pulses=%0d pending=%0d required 3/0", n_done, sb_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_a = 16'h7777; in_b = 16'h0123; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {out_hi, out_lo} !== last_prod || last_prod === 32'h0) begin
            failures++;
            $display("FAIL areset_pre busy=%b out=%h required busy=1 out=%h (nonzero)",
                     busy, {out_hi, out_lo}, last_prod);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {out_hi, out_lo} !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate busy=%b done=%b out=%h required 0/0/00000000",
                     busy, done, {out_hi, out_lo});
        end
        last_prod = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(16'h0002, 16'h0002, 1'b0, 32'h0000_0004, "after_reset");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_async_reset();
        test_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle 16x16 shift-add multiplier producing a 32-bit product as two 16-bit halves. It sits directly upstream of the writeback 2:1 mux: `out_lo` (or `out_hi`) drives the mux `in_1` alongside the ALU result on `in_0`. Control asserts the mux select when a multiply instruction retires. Operands are captured on a start pulse, the product is computed over `WIDTH` cycles, and a one-cycle `done` pulse is raised. The result stays held until the next completion.

## Interface

Parameters:
- `WIDTH`, 16, operand width. Product width is 2*`WIDTH`; the counter is sized to hold `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`
- `in_a`  in  `WIDTH`  multiplicand; sampled with `start`
- `in_b`  in  `WIDTH`  multiplier; sampled with `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle completion pulse (high only in DONE)
- `out_lo`  out  `WIDTH`  product bits [WIDTH-1:0], registered
- `out_hi`  out  `WIDTH`  product bits [2*WIDTH-1:WIDTH], registered

## Operation

- States: IDLE, RUN, DONE. Encoding is free; only the three states exist.
- IDLE:
  - If `start`=1, latch operand magnitudes: the absolute value when `signed_mode`=1 and the MSB is set, else the raw value.
  - Latch the result sign as `signed_mode` & (a[MSB] ^ b[MSB]).
  - Clear the 2*`WIDTH` accumulator and the counter, then go to RUN.
- RUN, one step per cycle:
  - If multiplier bit 0 is 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
  - After `WIDTH` steps, go to DONE.
- RUN-to-DONE edge:
  - Load `out_hi`:`out_lo` with the accumulator, two's-complement negated if the latched sign is 1.
  - All arithmetic is in 2*`WIDTH` bits; no overflow is possible.
- DONE: lasts exactly one cycle, then returns unconditionally to IDLE.
- `start` in RUN or DONE is ignored and not queued. Operand and `signed_mode` changes outside the IDLE sample have no effect.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as an unsigned `WIDTH`-bit value. No special case is needed.
- `out_lo`/`out_hi` change only on the RUN-to-DONE edge and otherwise hold their value, including through IDLE and new RUNs.

## Timing

- Reset: `reset_n`=0 immediately forces state IDLE, `busy`=0, `done`=0, `out_lo`=0, `out_hi`=0, accumulator and counter = 0. This holds regardless of the clock, including mid-RUN; an in-flight operation is discarded.
- Release: the first edge with `reset_n`=1 may accept `start`.
- Latency:
  - `start` is sampled at edge E0 in IDLE.
  - `busy`=1 from after E0 through E`WIDTH`.
  - At E`WIDTH` (E16 by default) the outputs update, `busy`=0 and `done`=1.
  - At E`WIDTH`+1, `done`=0 and the state is IDLE.
- Throughput: the earliest next accepted `start` is at E`WIDTH`+2, so there is one operation per `WIDTH`+2 cycles.
- `busy` and `done` are never high together. Both are registered (state-decoded from registered state) and glitch-free.
- The outputs are valid for downstream use in the `done` cycle and remain stable afterwards.

## Test plan

- Reset, then unsigned 0x0003 x 0x0005 with `start` for one cycle:
  - `busy` high for 16 cycles, then `done` for exactly 1 cycle.
  - `out_hi`=0x0000, `out_lo`=0x000F.
- Unsigned 0xFFFF x 0xFFFF -> `out_hi`=0xFFFE, `out_lo`=0x0001.
- Signed cases:
  - 0xFFFD x 0x0004 (-3 x 4) -> `out_hi`=0xFFFF, `out_lo`=0xFFF4.
  - 0x8000 x 0x8000 -> `out_hi`=0x4000, `out_lo`=0x0000.
  - 0x8000 x 0x0001 -> `out_hi`=0xFFFF, `out_lo`=0x8000.
- Hold `start`=1 continuously with changing operands:
  - Only the operands sampled in IDLE are used.
  - Completions are spaced 18 cycles apart.
  - Outputs hold between `done` pulses.
- Assert `reset_n`=0 between clock edges at RUN step 7:
  - `busy`, `done`, `out_lo` and `out_hi` go to 0 immediately.
  - After release, the next `start` of 0x0002 x 0x0002 yields 0x0000_0004 with normal latency.
- Zero operand: 0x0000 x 0x1234 (signed and unsigned) -> 0x0000_0000, with the same 16-cycle latency.
